// File: rtl/eth_rx_frame_ctrl.sv
// eth_rx_frame_ctrl
// RMII/MII receive frame controller. Finds preamble/SFD on the raw symbol
// stream, gates the external deserializer, holds back the last four bytes so
// the FCS never reaches the CRC engine, filters on DA/EtherType, checks
// length and CRC, and reports one status pulse per frame.
module eth_rx_frame_ctrl #(
  parameter int MII_WIDTH    = 2,
  parameter int PREAMBLE_MIN = 8,
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518,
  parameter int CRC_LAT      = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [MII_WIDTH-1:0] Rxd,
  input  logic                 Crs_Dv,
  input  logic                 Byte_Rdy,
  input  logic [7:0]           Byte,
  input  logic [47:0]          Mac_Addr,
  input  logic                 Promisc,
  input  logic                 Type_Flt_En,
  input  logic [31:0]          Crc_Computed,
  output logic                 Rx_En,
  output logic                 Crc_Clr,
  output logic [7:0]           Crc_Byte,
  output logic                 Crc_Byte_Vld,
  output logic                 Frm_Done,
  output logic                 Frm_Good,
  output logic [3:0]           Frm_Status,
  output logic [15:0]          Frm_Len,
  output logic [15:0]          Eth_Type
);

  // Symbol patterns: preamble is 01 repeated; SFD is preamble with its MSB set
  localparam logic [MII_WIDTH-1:0] SYM_PRE = {(MII_WIDTH/2){2'b01}};
  localparam logic [MII_WIDTH-1:0] SYM_SFD = SYM_PRE | {1'b1, {(MII_WIDTH-1){1'b0}}};

  localparam logic [7:0]  PRE_SAT  = 8'(64 / MII_WIDTH);
  localparam logic [7:0]  PRE_MIN  = 8'(PREAMBLE_MIN);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME);
  localparam logic [15:0] LEN_SAT  = 16'(MAX_FRAME + 1);
  localparam logic [7:0]  CRC_WAIT = 8'(CRC_LAT);
  localparam logic [7:0]  IPG_LAST = 8'(96 / MII_WIDTH - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_IPG   = 3'd4;

  logic [2:0]      state;
  logic [7:0]      preCnt;
  logic            lowSeen;
  logic [7:0]      waitCnt;
  logic [7:0]      ipgCnt;

  // Delay line: dLine[0] is the oldest byte, dLine[3] the newest, so the
  // packed vector is directly the little-endian FCS once the frame ends.
  logic [3:0][7:0] dLine;
  logic [2:0]      fill;
  logic [15:0]     byteCnt;
  logic            daMatch;
  logic            daBcast;
  logic [15:0]     typeReg;

  logic            symPre;
  logic            symSfd;
  logic            sfdAccept;
  logic            byteAccept;
  logic [7:0]      macByte;
  logic            crcErr;
  logic            lenErr;
  logic            addrMiss;
  logic            typeMiss;
  logic [3:0]      status;

  // Symbol decode, frame acceptance and end-of-frame status evaluation
  always_comb begin
    symPre     = Crs_Dv && (Rxd == SYM_PRE);
    symSfd     = Crs_Dv && (Rxd == SYM_SFD);
    sfdAccept  = (state == ST_PRE) && symSfd && (preCnt >= PRE_MIN);
    byteAccept = (state == ST_DATA) && Byte_Rdy;

    crcErr   = (byteCnt < 16'd4) || (Crc_Computed != dLine);
    lenErr   = (byteCnt < MIN_LEN) || (byteCnt > MAX_LEN);
    addrMiss = !Promisc && !((byteCnt >= 16'd6) && (daMatch || daBcast));
    typeMiss = Type_Flt_En && (typeReg != 16'h0800) && (typeReg != 16'h0806);
    status   = {crcErr, lenErr, addrMiss, typeMiss};
  end

  // Local MAC byte expected at the current DA position (wire order MSB first)
  always_comb begin
    macByte = '0;
    case (byteCnt[2:0])
      3'd0:    macByte = Mac_Addr[47:40];
      3'd1:    macByte = Mac_Addr[39:32];
      3'd2:    macByte = Mac_Addr[31:24];
      3'd3:    macByte = Mac_Addr[23:16];
      3'd4:    macByte = Mac_Addr[15:8];
      3'd5:    macByte = Mac_Addr[7:0];
      default: macByte = '0;
    endcase
  end

  // Frame FSM: preamble hunt, data phase, CRC wait, status report, IPG
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_IDLE;
      preCnt     <= '0;
      lowSeen    <= 1'b0;
      waitCnt    <= '0;
      ipgCnt     <= '0;
      Rx_En      <= 1'b0;
      Crc_Clr    <= 1'b0;
      Frm_Done   <= 1'b0;
      Frm_Good   <= 1'b0;
      Frm_Status <= '0;
      Frm_Len    <= '0;
      Eth_Type   <= '0;
    end else begin
      Crc_Clr  <= 1'b0;
      Frm_Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (symPre) begin
            state  <= ST_PRE;
            preCnt <= 8'd1;
          end
        end
        ST_PRE: begin
          if (sfdAccept) begin
            state   <= ST_DATA;
            Rx_En   <= 1'b1;
            Crc_Clr <= 1'b1;
            lowSeen <= 1'b0;
          end else if (symPre) begin
            if (preCnt != PRE_SAT) preCnt <= preCnt + 8'd1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (!Crs_Dv) begin
            if (lowSeen) begin
              state   <= ST_CHECK;
              Rx_En   <= 1'b0;
              waitCnt <= '0;
            end else begin
              lowSeen <= 1'b1;
            end
          end else begin
            lowSeen <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (waitCnt == CRC_WAIT) begin
            Frm_Done   <= 1'b1;
            Frm_Good   <= ~|status;
            Frm_Status <= status;
            Frm_Len    <= byteCnt;
            Eth_Type   <= typeReg;
            ipgCnt     <= '0;
            state      <= ST_IPG;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        ST_IPG: begin
          if (ipgCnt == IPG_LAST) state <= ST_IDLE;
          else                    ipgCnt <= ipgCnt + 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Byte datapath: 4-byte delay line, length count, DA and EtherType capture
  always_ff @(posedge Clk) begin
    if (Rst) begin
      dLine        <= '0;
      fill         <= '0;
      byteCnt      <= '0;
      daMatch      <= 1'b0;
      daBcast      <= 1'b0;
      typeReg      <= '0;
      Crc_Byte     <= '0;
      Crc_Byte_Vld <= 1'b0;
    end else begin
      Crc_Byte_Vld <= 1'b0;
      if (sfdAccept) begin
        dLine   <= '0;
        fill    <= '0;
        byteCnt <= '0;
        daMatch <= 1'b1;
        daBcast <= 1'b1;
        typeReg <= '0;
      end else if (byteAccept) begin
        dLine <= {Byte, dLine[3:1]};
        if (fill == 3'd4) begin
          Crc_Byte     <= dLine[0];
          Crc_Byte_Vld <= 1'b1;
        end else begin
          fill <= fill + 3'd1;
        end
        if (byteCnt != LEN_SAT) byteCnt <= byteCnt + 16'd1;
        if (byteCnt < 16'd6) begin
          if (Byte != macByte) daMatch <= 1'b0;
          if (Byte != 8'hFF)   daBcast <= 1'b0;
        end
        if (byteCnt == 16'd12) typeReg[15:8] <= Byte;
        if (byteCnt == 16'd13) typeReg[7:0]  <= Byte;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// tb_eth_rx_frame_ctrl
// Directed bench: a W=2 controller for frame/filter/length/CRC behaviour and
// a W=8 controller for preamble-length acceptance.
module tb_eth_rx_frame_ctrl;

  localparam logic [47:0] MAC = 48'h02_1A_2B_3C_4D_5E;
  localparam logic [31:0] FCS = 32'hA1B2_C3D4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  Rxd;
  logic        Crs_Dv;
  logic [7:0]  Rxd8;
  logic        CrsDv8;
  logic        Byte_Rdy;
  logic [7:0]  Byte;
  logic [47:0] Mac_Addr;
  logic        Promisc;
  logic        Type_Flt_En;
  logic [31:0] Crc_Computed;

  logic        Rx_En, Crc_Clr, Crc_Byte_Vld, Frm_Done, Frm_Good;
  logic [7:0]  Crc_Byte;
  logic [3:0]  Frm_Status;
  logic [15:0] Frm_Len, Eth_Type;

  logic        Rx_En8, Crc_Clr8, Crc_Byte_Vld8, Frm_Done8, Frm_Good8;
  logic [7:0]  Crc_Byte8;
  logic [3:0]  Frm_Status8;
  logic [15:0] Frm_Len8, Eth_Type8;

  int          checks = 0;
  int          errors = 0;
  int          vldCnt = 0;
  int          doneCnt = 0;
  int          doneCnt8 = 0;
  logic [7:0]  lastCrcByte = '0;
  logic [7:0]  frm [0:1599];

  always #5 Clk = ~Clk;

  eth_rx_frame_ctrl #(.MII_WIDTH(2), .PREAMBLE_MIN(8), .MIN_FRAME(64), .MAX_FRAME(1518), .CRC_LAT(2)) dut (
    .Clk(Clk), .Rst(Rst), .Rxd(Rxd), .Crs_Dv(Crs_Dv), .Byte_Rdy(Byte_Rdy), .Byte(Byte),
    .Mac_Addr(Mac_Addr), .Promisc(Promisc), .Type_Flt_En(Type_Flt_En), .Crc_Computed(Crc_Computed),
    .Rx_En(Rx_En), .Crc_Clr(Crc_Clr), .Crc_Byte(Crc_Byte), .Crc_Byte_Vld(Crc_Byte_Vld),
    .Frm_Done(Frm_Done), .Frm_Good(Frm_Good), .Frm_Status(Frm_Status), .Frm_Len(Frm_Len), .Eth_Type(Eth_Type)
  );

  eth_rx_frame_ctrl #(.MII_WIDTH(8), .PREAMBLE_MIN(7), .MIN_FRAME(64), .MAX_FRAME(1518), .CRC_LAT(2)) dut8 (
    .Clk(Clk), .Rst(Rst), .Rxd(Rxd8), .Crs_Dv(CrsDv8), .Byte_Rdy(Byte_Rdy), .Byte(Byte),
    .Mac_Addr(Mac_Addr), .Promisc(Promisc), .Type_Flt_En(Type_Flt_En), .Crc_Computed(Crc_Computed),
    .Rx_En(Rx_En8), .Crc_Clr(Crc_Clr8), .Crc_Byte(Crc_Byte8), .Crc_Byte_Vld(Crc_Byte_Vld8),
    .Frm_Done(Frm_Done8), .Frm_Good(Frm_Good8), .Frm_Status(Frm_Status8), .Frm_Len(Frm_Len8), .Eth_Type(Eth_Type8)
  );

  // Pulse counters, sampled mid-cycle
  always @(negedge Clk) begin
    if (Crc_Byte_Vld) begin
      vldCnt      <= vldCnt + 1;
      lastCrcByte <= Crc_Byte;
    end
    if (Frm_Done)  doneCnt  <= doneCnt + 1;
    if (Frm_Done8) doneCnt8 <= doneCnt8 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame(input int len, input logic [47:0] da, input logic [15:0] et, input bit flip);
    for (int i = 0; i < len; i++) frm[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 6; i++) frm[i] = da[47 - 8*i -: 8];
    frm[6] = 8'h02; frm[7] = 8'h00; frm[8] = 8'h00;
    frm[9] = 8'h00; frm[10] = 8'h00; frm[11] = 8'h01;
    frm[12] = et[15:8];
    frm[13] = et[7:0];
    frm[len-4] = FCS[7:0] ^ {7'd0, flip};
    frm[len-3] = FCS[15:8];
    frm[len-2] = FCS[23:16];
    frm[len-1] = FCS[31:24];
    Crc_Computed = FCS;
  endtask

  task automatic send_pre(input bit w8, input int n);
    for (int i = 0; i < n; i++) begin
      if (w8) begin CrsDv8 = 1'b1; Rxd8 = 8'h55; end
      else    begin Crs_Dv = 1'b1; Rxd  = 2'b01; end
      tick();
    end
    if (w8) Rxd8 = 8'hD5;
    else    Rxd  = 2'b11;
    tick();
  endtask

  task automatic send_bytes(input int len);
    Rxd = 2'b00;
    Rxd8 = 8'h00;
    for (int i = 0; i < len; i++) begin
      Byte = frm[i];
      Byte_Rdy = 1'b1;
      tick();
      Byte_Rdy = 1'b0;
      tick();
    end
  endtask

  task automatic finish_frame(input bit w8, output bit got);
    if (w8) CrsDv8 = 1'b0;
    else    Crs_Dv = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if ((w8 ? Frm_Done8 : Frm_Done) === 1'b1) got = 1'b1;
    end
  endtask

  task automatic rx_frame(input int len, input logic [47:0] da, input logic [15:0] et, input bit flip, output bit got);
    build_frame(len, da, et, flip);
    send_pre(1'b0, 31);
    send_bytes(len);
    finish_frame(1'b0, got);
  endtask

  initial begin
    bit got;
    int v0, d0;

    Rst = 1'b1; Rxd = '0; Crs_Dv = 1'b0; Rxd8 = '0; CrsDv8 = 1'b0;
    Byte_Rdy = 1'b0; Byte = '0; Mac_Addr = MAC; Promisc = 1'b0;
    Type_Flt_En = 1'b0; Crc_Computed = '0;
    idle(3);
    chk("rst_ctl",  {15'd0, Rx_En, Crc_Clr, Crc_Byte, Crc_Byte_Vld, Frm_Done, Frm_Good, Frm_Status}, 32'd0);
    chk("rst_len",  {16'd0, Frm_Len}, 32'd0);
    chk("rst_type", {16'd0, Eth_Type}, 32'd0);
    chk("rst_ctl8", {15'd0, Rx_En8, Crc_Clr8, Crc_Byte8, Crc_Byte_Vld8, Frm_Done8, Frm_Good8, Frm_Status8}, 32'd0);
    Rst = 1'b0;
    idle(5);

    // Good 64-byte unicast frame
    v0 = vldCnt; d0 = doneCnt;
    build_frame(64, MAC, 16'h0800, 1'b0);
    send_pre(1'b0, 31);
    chk("sfd_rx_en",  {31'd0, Rx_En}, 32'd1);
    chk("sfd_crc_clr", {31'd0, Crc_Clr}, 32'd1);
    send_bytes(64);
    finish_frame(1'b0, got);
    chk("f1_done",   {31'd0, got}, 32'd1);
    chk("f1_good",   {31'd0, Frm_Good}, 32'd1);
    chk("f1_status", {28'd0, Frm_Status}, 32'd0);
    chk("f1_len",    {16'd0, Frm_Len}, 32'd64);
    chk("f1_type",   {16'd0, Eth_Type}, 32'h0800);
    chk("f1_rx_en",  {31'd0, Rx_En}, 32'd0);
    idle(60);
    chk("f1_vld_cnt", vldCnt - v0, 32'd60);
    chk("f1_done_cnt", doneCnt - d0, 32'd1);
    chk("f1_last_byte", {24'd0, lastCrcByte}, {24'd0, frm[59]});

    // Corrupted FCS
    rx_frame(64, MAC, 16'h0800, 1'b1, got);
    chk("crc_status", {28'd0, Frm_Status}, 32'h8);
    chk("crc_good",   {31'd0, Frm_Good}, 32'd0);
    idle(60);

    // Broadcast DA, IPv6 type, type filter on then off
    Type_Flt_En = 1'b1;
    rx_frame(64, 48'hFFFF_FFFF_FFFF, 16'h86DD, 1'b0, got);
    chk("tflt_status", {28'd0, Frm_Status}, 32'h1);
    chk("tflt_type",   {16'd0, Eth_Type}, 32'h86DD);
    idle(60);
    Type_Flt_En = 1'b0;
    rx_frame(64, 48'hFFFF_FFFF_FFFF, 16'h86DD, 1'b0, got);
    chk("tnoflt_status", {28'd0, Frm_Status}, 32'h0);
    chk("tnoflt_good",   {31'd0, Frm_Good}, 32'd1);
    idle(60);

    // Foreign unicast DA, then the same with promiscuous mode
    rx_frame(64, 48'h02_1A_2B_3C_4D_5F, 16'h0806, 1'b0, got);
    chk("da_miss_status", {28'd0, Frm_Status}, 32'h2);
    idle(60);
    Promisc = 1'b1;
    rx_frame(64, 48'h02_1A_2B_3C_4D_5F, 16'h0806, 1'b0, got);
    chk("promisc_status", {28'd0, Frm_Status}, 32'h0);
    idle(60);
    Promisc = 1'b0;

    // Runt and oversize frames
    v0 = vldCnt;
    rx_frame(40, MAC, 16'h0800, 1'b0, got);
    chk("runt_status", {28'd0, Frm_Status}, 32'h4);
    chk("runt_len",    {16'd0, Frm_Len}, 32'd40);
    idle(60);
    chk("runt_vld_cnt", vldCnt - v0, 32'd36);
    v0 = vldCnt;
    rx_frame(1600, MAC, 16'h0800, 1'b0, got);
    chk("giant_status", {28'd0, Frm_Status}, 32'h4);
    chk("giant_len",    {16'd0, Frm_Len}, 32'd1519);
    idle(60);
    chk("giant_vld_cnt", vldCnt - v0, 32'd1596);

    // Preamble arriving inside the inter-packet gap is ignored
    d0 = doneCnt;
    rx_frame(64, MAC, 16'h0800, 1'b0, got);
    chk("ipg_first_done", {31'd0, got}, 32'd1);
    send_pre(1'b0, 10);
    chk("ipg_rx_en", {31'd0, Rx_En}, 32'd0);
    Crs_Dv = 1'b0;
    idle(60);
    chk("ipg_done_cnt", doneCnt - d0, 32'd1);

    // Reset in the middle of a payload
    d0 = doneCnt;
    build_frame(64, MAC, 16'h0800, 1'b0);
    send_pre(1'b0, 31);
    send_bytes(20);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("mid_rst_ctl",  {15'd0, Rx_En, Crc_Clr, Crc_Byte, Crc_Byte_Vld, Frm_Done, Frm_Good, Frm_Status}, 32'd0);
    chk("mid_rst_len",  {16'd0, Frm_Len}, 32'd0);
    chk("mid_rst_type", {16'd0, Eth_Type}, 32'd0);
    Crs_Dv = 1'b0;
    idle(60);
    chk("mid_rst_no_done", doneCnt - d0, 32'd0);
    rx_frame(64, MAC, 16'h0800, 1'b0, got);
    chk("post_rst_done",   {31'd0, got}, 32'd1);
    chk("post_rst_good",   {31'd0, Frm_Good}, 32'd1);
    chk("post_rst_len",    {16'd0, Frm_Len}, 32'd64);
    idle(60);

    // W=8: short preambles rejected, minimum-length preamble accepted
    d0 = doneCnt8;
    send_pre(1'b1, 3);
    chk("w8_pre3_rx_en", {31'd0, Rx_En8}, 32'd0);
    CrsDv8 = 1'b0;
    idle(5);
    send_pre(1'b1, 6);
    chk("w8_pre6_rx_en", {31'd0, Rx_En8}, 32'd0);
    CrsDv8 = 1'b0;
    idle(20);
    chk("w8_reject_no_done", doneCnt8 - d0, 32'd0);
    build_frame(64, MAC, 16'h0800, 1'b0);
    send_pre(1'b1, 7);
    chk("w8_pre7_rx_en", {31'd0, Rx_En8}, 32'd1);
    send_bytes(64);
    finish_frame(1'b1, got);
    chk("w8_done",   {31'd0, got}, 32'd1);
    chk("w8_good",   {31'd0, Frm_Good8}, 32'd1);
    chk("w8_status", {28'd0, Frm_Status8}, 32'h0);
    chk("w8_len",    {16'd0, Frm_Len8}, 32'd64);
    idle(20);
    chk("w8_done_cnt", doneCnt8 - d0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
